// File: rtl/cb_policy_ctrl.sv
// Circuit-breaker policy controller: confirms ML alerts, escalates by severity,
// enforces post-release cooldown and gives host overrides top priority.
// Optional trip statistics counter enabled by defining CB_CTRL_STATS_EN.
module cb_policy_ctrl #(
  parameter int unsigned CONFIRM_N    = 3,
  parameter int unsigned CONF_MIN     = 64,
  parameter int unsigned PARAM_CAP    = 200,
  parameter int unsigned COOLDOWN_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ml_valid,
  input  logic [1:0] ml_class,
  input  logic [7:0] ml_conf,
  input  logic       host_valid,
  input  logic [1:0] host_mode,
  input  logic [7:0] host_param,
  input  logic       ob_cb_active,
  input  logic [1:0] ob_cb_state,
  output logic [1:0] cb_mode,
  output logic [7:0] cb_param,
  output logic       cb_load,
  output logic [1:0] ctrl_state,
  output logic [7:0] trip_count
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned TMR_W     = 8;
  localparam int unsigned GUARD_CYC = 2;
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(CONFIRM_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ENGAGED  = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cls_q, cls_d;
  logic [1:0]       guard_q, guard_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       param_q, param_d;
  logic             load_q, load_d;

  logic       ml_qual;
  logic [7:0] ml_param;
  logic       issue;
  logic [1:0] iss_mode;
  logic [7:0] iss_param;

  assign ml_qual  = ml_valid && (ml_class != 2'd0) && (ml_conf >= 8'(CONF_MIN));
  assign ml_param = (ml_conf > 8'(PARAM_CAP)) ? 8'(PARAM_CAP) : ml_conf;

  // Next-state and issue decision; host strobes pre-empt (and swallow) ML alerts
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_d     = cls_q;
    timer_d   = timer_q;
    guard_d   = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    issue     = 1'b0;
    iss_mode  = ml_class;
    iss_param = ml_param;
    if (host_valid) begin
      issue     = 1'b1;
      iss_mode  = host_mode;
      iss_param = host_param;
      cnt_d     = '0;
      state_d   = (host_mode != 2'd0) ? ST_ENGAGED : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ml_qual) begin
            if (CONFIRM_N <= 1) begin
              issue   = 1'b1;
              state_d = ST_ENGAGED;
            end else begin
              state_d = ST_ARMED;
              cnt_d   = CNT_W'(1);
              cls_d   = ml_class;
            end
          end
        end
        ST_ARMED: begin
          if (ml_valid && (ml_class == 2'd0)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (ml_qual) begin
            if (ml_class == cls_q) begin
              if (cnt_q >= CNT_TRIP) begin
                issue   = 1'b1;
                state_d = ST_ENGAGED;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_d = CNT_W'(1);
              cls_d = ml_class;
            end
          end
        end
        ST_ENGAGED: begin
          if (ml_qual && (ml_class > mode_q)) begin
            issue = 1'b1;
          end else if ((guard_q == 2'd0) && !ob_cb_active) begin
            state_d = ST_COOLDOWN;
            timer_d = TMR_W'(COOLDOWN_CYC);
          end
        end
        ST_COOLDOWN: begin
          if (ml_qual && (ml_class == 2'd3)) begin
            issue   = 1'b1;
            state_d = ST_ENGAGED;
          end else begin
            timer_d = timer_q - TMR_W'(1);
            if (timer_q <= TMR_W'(1)) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (issue) guard_d = 2'(GUARD_CYC);
    mode_d  = issue ? iss_mode : mode_q;
    param_d = issue ? iss_param : param_q;
    load_d  = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cls_q   <= '0;
      guard_q <= '0;
      timer_q <= '0;
      mode_q  <= '0;
      param_q <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      guard_q <= guard_d;
      timer_q <= timer_d;
      mode_q  <= mode_d;
      param_q <= param_d;
      load_q  <= load_d;
    end
  end

  assign cb_mode    = mode_q;
  assign cb_param   = param_q;
  assign cb_load    = load_q;
  assign ctrl_state = state_q;

`ifdef CB_CTRL_STATS_EN
  logic [7:0] trip_q, trip_d;

  // Saturating count of every nonzero-mode issue
  always_comb begin
    trip_d = trip_q;
    if (issue && (iss_mode != 2'd0) && (trip_q != 8'hFF)) trip_d = trip_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) trip_q <= '0;
    else     trip_q <= trip_d;
  end

  assign trip_count = trip_q;
`else
  assign trip_count = 8'd0;
`endif

  // Order-book state is observed for visibility only; no policy depends on it
  logic unused_ob_state;
  assign unused_ob_state = ^ob_cb_state;

endmodule

// File: tb/tb_cb_policy_ctrl.sv
// Scoreboard bench for cb_policy_ctrl: directed test-plan scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_cb_policy_ctrl;

`ifdef CB_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int IDLE = 0, ARMED = 1, ENG = 2, COOL = 3;
  localparam int CONFIRM_N = 3, CONF_MIN = 64, PARAM_CAP = 200, COOLDOWN_CYC = 32;

  logic       clk = 1'b0;
  logic       rst, ml_valid, host_valid, ob_cb_active;
  logic [1:0] ml_class, host_mode, ob_cb_state;
  logic [7:0] ml_conf, host_param;
  logic [1:0] cb_mode, ctrl_state;
  logic [7:0] cb_param, trip_count;
  logic       cb_load;

  cb_policy_ctrl dut (
    .clk(clk), .rst(rst), .ml_valid(ml_valid), .ml_class(ml_class), .ml_conf(ml_conf),
    .host_valid(host_valid), .host_mode(host_mode), .host_param(host_param),
    .ob_cb_active(ob_cb_active), .ob_cb_state(ob_cb_state),
    .cb_mode(cb_mode), .cb_param(cb_param), .cb_load(cb_load),
    .ctrl_state(ctrl_state), .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  typedef struct {
    int st; int ld; int md; int pm; int tc;
  } exp_t;
  typedef struct {
    int md; int pm;
  } iss_t;
  exp_t exp_q[$];
  iss_t iss_q[$];

  // Reference model state
  int m_st = IDLE, m_cnt = 0, m_cls = 0, m_mode = 0, m_param = 0;
  int m_trips = 0, m_since = 100, m_cool = 0, m_load = 0;
  bit ob_lvl = 1'b1;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One cycle of the policy rules, applied to the inputs just driven
  task automatic model_step();
    int c, cf, nm, np;
    bit q, issue;
    exp_t e;
    iss_t i;
    c  = int'(ml_class);
    cf = int'(ml_conf);
    q  = ml_valid && (c != 0) && (cf >= CONF_MIN);
    issue = 0; nm = 0; np = 0;
    if (rst) begin
      m_st = IDLE; m_cnt = 0; m_cls = 0; m_mode = 0; m_param = 0;
      m_trips = 0; m_since = 100; m_cool = 0; m_load = 0;
    end else begin
      if (m_since < 100) m_since++;
      if (host_valid) begin
        issue = 1; nm = int'(host_mode); np = int'(host_param);
        m_cnt = 0;
        m_st = (nm != 0) ? ENG : IDLE;
      end else begin
        case (m_st)
          IDLE: if (q) begin
            m_st = ARMED; m_cnt = 1; m_cls = c;
          end
          ARMED: begin
            if (ml_valid && c == 0) begin
              m_st = IDLE; m_cnt = 0;
            end else if (q) begin
              if (c == m_cls) begin
                m_cnt++;
                if (m_cnt == CONFIRM_N) begin
                  issue = 1; nm = c; np = (cf > PARAM_CAP) ? PARAM_CAP : cf;
                  m_st = ENG; m_cnt = 0;
                end
              end else begin
                m_cnt = 1; m_cls = c;
              end
            end
          end
          ENG: begin
            if (q && c > m_mode) begin
              issue = 1; nm = c; np = (cf > PARAM_CAP) ? PARAM_CAP : cf;
            end else if (m_since >= 2 && !ob_cb_active) begin
              m_st = COOL; m_cool = COOLDOWN_CYC;
            end
          end
          default: begin
            if (q && c == 3) begin
              issue = 1; nm = 3; np = (cf > PARAM_CAP) ? PARAM_CAP : cf;
              m_st = ENG;
            end else begin
              m_cool--;
              if (m_cool == 0) m_st = IDLE;
            end
          end
        endcase
      end
      m_load = issue;
      if (issue) begin
        m_mode = nm; m_param = np; m_since = -1;
        if (nm != 0 && m_trips < 255) m_trips++;
        i.md = nm; i.pm = np;
        iss_q.push_back(i);
      end
    end
    e.st = m_st; e.ld = m_load; e.md = m_mode; e.pm = m_param;
    e.tc = STATS ? m_trips : 0;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit mv, input int mc, input int cf,
                     input bit hv, input int hm, input int hp);
    @(posedge clk);
    #2;
    rst = r; ml_valid = mv; ml_class = 2'(mc); ml_conf = 8'(cf);
    host_valid = hv; host_mode = 2'(hm); host_param = 8'(hp);
    ob_cb_active = ob_lvl; ob_cb_state = 2'($urandom);
    model_step();
  endtask

  task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0);    endtask
  task automatic alert(input int c, input int cf); cyc(0, 1, c, cf, 0, 0, 0); endtask
  task automatic reset2();          cyc(1, 0, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0, 0); endtask

  // Monitor: per-cycle expectations plus issue queue popped on every cb_load
  initial begin
    exp_t e;
    iss_t i;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl_state", int'(ctrl_state), e.st);
        chk("cb_load", int'(cb_load), e.ld);
        chk("cb_mode", int'(cb_mode), e.md);
        chk("cb_param", int'(cb_param), e.pm);
        chk("trip_count", int'(trip_count), e.tc);
      end
      if (cb_load === 1'b1) begin
        chk("load_expected", int'(iss_q.size() > 0), 1);
        if (iss_q.size() > 0) begin
          i = iss_q.pop_front();
          chk("issue_mode", int'(cb_mode), i.md);
          chk("issue_param", int'(cb_param), i.pm);
        end
      end
    end
  end

  initial begin
    int last_c;
    rst = 1'b1; ml_valid = 0; ml_class = 0; ml_conf = 0; host_valid = 0;
    host_mode = 0; host_param = 0; ob_cb_active = 1; ob_cb_state = 0;

    // Basic confirmation trip
    reset2();
    chk("reset_state", int'(ctrl_state), IDLE);
    alert(2, 100); alert(2, 100); alert(2, 100); idle();
    chk("t1_load", int'(cb_load), 1);
    chk("t1_mode", int'(cb_mode), 2);
    chk("t1_param", int'(cb_param), 100);
    chk("t1_state", int'(ctrl_state), ENG);

    // Param cap, escalation, ignored lower severity
    reset2();
    alert(1, 250); alert(1, 250); alert(1, 250); idle();
    chk("t2_cap", int'(cb_param), 200);
    alert(3, 80); idle();
    chk("t2_esc_load", int'(cb_load), 1);
    chk("t2_esc_mode", int'(cb_mode), 3);
    chk("t2_esc_param", int'(cb_param), 80);
    alert(2, 100); idle();
    chk("t2_lower_ignored", int'(cb_load), 0);

    // Class-0 abort, class-switch restart
    reset2();
    alert(1, 100); alert(1, 100); alert(0, 100); idle();
    chk("t3_abort_load", int'(cb_load), 0);
    chk("t3_abort_state", int'(ctrl_state), IDLE);
    alert(1, 100); alert(2, 100); alert(2, 100); alert(2, 100); idle();
    chk("t3_switch_load", int'(cb_load), 1);
    chk("t3_switch_mode", int'(cb_mode), 2);

    // Cooldown entry, filtering, flash-crash bypass
    reset2();
    alert(2, 100); alert(2, 100); alert(2, 100); idle(); idle();
    ob_lvl = 0; idle(); idle();
    chk("t4_cooldown", int'(ctrl_state), COOL);
    alert(2, 100); alert(2, 100); alert(2, 100); idle();
    chk("t4_filtered", int'(ctrl_state), COOL);
    alert(3, 64); ob_lvl = 1; idle();
    chk("t4_flash_load", int'(cb_load), 1);
    chk("t4_flash_mode", int'(cb_mode), 3);
    repeat (4) idle();

    // Host override beats a simultaneous ML alert; host mode 0 returns to idle
    reset2();
    cyc(0, 1, 2, 100, 1, 3, 5); idle();
    chk("t5_host_mode", int'(cb_mode), 3);
    chk("t5_host_param", int'(cb_param), 5);
    cyc(0, 0, 0, 0, 1, 0, 7); idle();
    chk("t5_host0_load", int'(cb_load), 1);
    chk("t5_host0_state", int'(ctrl_state), IDLE);

    // Reset while armed
    alert(1, 100); alert(1, 100);
    cyc(1, 0, 0, 0, 0, 0, 0); idle();
    chk("t6_rst_param", int'(cb_param), 0);
    chk("t6_rst_state", int'(ctrl_state), IDLE);
    chk("t6_rst_trips", int'(trip_count), 0);
    alert(1, 100); alert(1, 100); idle();
    chk("t6_no_early_trip", int'(ctrl_state), ARMED);
    alert(1, 100); idle();
    chk("t6_trip_load", int'(cb_load), 1);
    chk("t6_trip_count", int'(trip_count), STATS ? 1 : 0);

    // Randomized traffic
    last_c = 1;
    for (int n = 0; n < 3000; n++) begin
      bit r, mv, hv;
      int c;
      if ($urandom_range(0, 15) == 0) ob_lvl = ~ob_lvl;
      r  = ($urandom_range(0, 199) == 0);
      hv = ($urandom_range(0, 39) == 0);
      mv = $urandom_range(0, 1);
      c  = ($urandom_range(0, 1) == 1) ? last_c : int'($urandom_range(0, 3));
      last_c = c;
      cyc(r, mv, c, int'($urandom_range(40, 255)), hv,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end

    ob_lvl = 1;
    idle(); idle(); idle();
    @(posedge clk);
    #3;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("issue_queue_drained", iss_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
